// File: rtl/multicycle_control_if.sv
// Memory request/ready handshake between the sequencer and memory.
// The controller is the master; memory answers with mem_ready.
interface multicycle_control_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output iord,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  iord,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore sequencer for the multi-cycle CPU datapath.
// Walks fetch/decode/execute/memory/writeback with a stalling memory handshake.
module multicycle_control #(
  parameter int OPC_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero,
  multicycle_control_if.master mem,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             halted,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_R     = 4'd7,
    S_WB_I     = 4'd8,
    S_WB_LD    = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_HALT     = 4'd12
  } state_t;

  localparam logic [OPC_W-1:0] OP_R    = OPC_W'(4'b0000);
  localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(4'b0001);
  localparam logic [OPC_W-1:0] OP_ANDI = OPC_W'(4'b0010);
  localparam logic [OPC_W-1:0] OP_ORI  = OPC_W'(4'b0011);
  localparam logic [OPC_W-1:0] OP_SLTI = OPC_W'(4'b0100);
  localparam logic [OPC_W-1:0] OP_LW   = OPC_W'(4'b1000);
  localparam logic [OPC_W-1:0] OP_SW   = OPC_W'(4'b1001);
  localparam logic [OPC_W-1:0] OP_BEQ  = OPC_W'(4'b1010);
  localparam logic [OPC_W-1:0] OP_BNE  = OPC_W'(4'b1011);
  localparam logic [OPC_W-1:0] OP_J    = OPC_W'(4'b1100);
  localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(4'b1111);

  state_t           state_q, state_d;
  logic [OPC_W-1:0] opc_q, opc_d;

  logic is_r, is_addi, is_andi, is_ori, is_slti;
  logic is_lw, is_sw, is_beq, is_bne, is_j, is_halt;
  logic is_ialu;

  // Live opcode in DECODE, latched copy everywhere after.
  always_comb begin
    opc_d = (state_q == S_DECODE) ? opcode : opc_q;
  end

  always_comb begin
    is_r    = (opc_d == OP_R);
    is_addi = (opc_d == OP_ADDI);
    is_andi = (opc_d == OP_ANDI);
    is_ori  = (opc_d == OP_ORI);
    is_slti = (opc_d == OP_SLTI);
    is_lw   = (opc_d == OP_LW);
    is_sw   = (opc_d == OP_SW);
    is_beq  = (opc_d == OP_BEQ);
    is_bne  = (opc_d == OP_BNE);
    is_j    = (opc_d == OP_J);
    is_halt = (opc_d == OP_HALT);
    is_ialu = is_addi | is_andi | is_ori | is_slti;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:    if (mem.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          is_r:          state_d = S_EXEC_R;
          is_ialu:       state_d = S_EXEC_I;
          is_lw, is_sw:  state_d = S_MEM_ADDR;
          is_beq,
          is_bne:        state_d = S_BRANCH;
          is_j:          state_d = S_JUMP;
          is_halt:       state_d = S_HALT;
          default:       state_d = S_FETCH;
        endcase
      end
      S_EXEC_R:   state_d = S_WB_R;
      S_EXEC_I:   state_d = S_WB_I;
      S_MEM_ADDR: state_d = is_lw ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem.mem_ready) state_d = S_WB_LD;
      S_MEM_WR:   if (mem.mem_ready) state_d = S_FETCH;
      S_WB_R,
      S_WB_I,
      S_WB_LD,
      S_BRANCH,
      S_JUMP:     state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      opc_q   <= '0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
    end
  end

  // Reset forces every output low, even mid-handshake.
  always_comb begin
    mem.mem_req = 1'b0;
    mem.mem_we  = 1'b0;
    mem.iord    = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 2'b00;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_op      = 3'b000;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    halted      = 1'b0;
    if (!reset) begin
      unique case (state_q)
        S_FETCH: begin
          mem.mem_req = 1'b1;
          alu_src_b   = 2'b01;
          ir_write    = mem.mem_ready;
          pc_write    = mem.mem_ready;
        end
        S_DECODE: alu_src_b = 2'b11;
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = 3'b010;
        end
        S_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          unique case (1'b1)
            is_andi: alu_op = 3'b100;
            is_ori:  alu_op = 3'b001;
            is_slti: alu_op = 3'b110;
            default: alu_op = 3'b000;
          endcase
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEM_RD: begin
          mem.mem_req = 1'b1;
          mem.iord    = 1'b1;
        end
        S_MEM_WR: begin
          mem.mem_req = 1'b1;
          mem.mem_we  = 1'b1;
          mem.iord    = 1'b1;
        end
        S_WB_R: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_WB_I:   reg_write = 1'b1;
        S_WB_LD: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          alu_op    = 3'b101;
          pc_src    = 2'b01;
          pc_write  = is_bne ? ~zero : zero;
        end
        S_JUMP: begin
          pc_src   = 2'b10;
          pc_write = 1'b1;
        end
        S_HALT:   halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign state = reset ? S_FETCH : state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks instruction classes,
// memory stalls, reset aborts and halt, with hand-computed outputs.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] opcode;
  logic       zero;
  logic       ir_write, pc_write, alu_src_a;
  logic       reg_write, reg_dst, mem_to_reg, halted;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] alu_op;
  logic [3:0] state;

  int total  = 0;
  int passed = 0;

  multicycle_control_if mif ();

  multicycle_control #(.OPC_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
    .mem        (mif),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .halted     (halted),
    .state      (state)
  );

  always #5 clk = ~clk;

  // {req,we,iord,irw,pcw,pc_src,a,b,alu_op,rw,dst,m2r,halted}
  logic [16:0] outs;
  assign outs = {mif.mem_req, mif.mem_we, mif.iord, ir_write, pc_write,
                 pc_src, alu_src_a, alu_src_b, alu_op,
                 reg_write, reg_dst, mem_to_reg, halted};

  localparam logic [16:0] V_ZERO = 17'b0;
  localparam logic [16:0] V_F1   = 17'b10011_00_0_01_000_0000;
  localparam logic [16:0] V_F0   = 17'b10000_00_0_01_000_0000;
  localparam logic [16:0] V_DEC  = 17'b00000_00_0_11_000_0000;
  localparam logic [16:0] V_EXR  = 17'b00000_00_1_00_010_0000;
  localparam logic [16:0] V_WBR  = 17'b00000_00_0_00_000_1100;
  localparam logic [16:0] V_MA   = 17'b00000_00_1_10_000_0000;
  localparam logic [16:0] V_MR   = 17'b10100_00_0_00_000_0000;
  localparam logic [16:0] V_WBLD = 17'b00000_00_0_00_000_1010;
  localparam logic [16:0] V_BR1  = 17'b00001_01_1_00_101_0000;
  localparam logic [16:0] V_BR0  = 17'b00000_01_1_00_101_0000;
  localparam logic [16:0] V_EXIA = 17'b00000_00_1_10_100_0000;
  localparam logic [16:0] V_WBI  = 17'b00000_00_0_00_000_1000;
  localparam logic [16:0] V_MW   = 17'b11100_00_0_00_000_0000;
  localparam logic [16:0] V_JMP  = 17'b00001_10_0_00_000_0000;
  localparam logic [16:0] V_HALT = 17'b00000_00_0_00_000_0001;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cs(input string tag, input logic [3:0] st,
                    input logic [16:0] v);
    chk({tag, "_st"}, 32'(state), 32'(st));
    chk({tag, "_out"}, 32'(outs), 32'(v));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    opcode = 4'h0;
    zero = 1'b0;
    mif.mem_ready = 1'b1;
    @(negedge clk); #1; cs("reset", 4'd0, V_ZERO);

    // R-type
    @(negedge clk); reset = 1'b0; #1; cs("r_fetch", 4'd0, V_F1);
    @(negedge clk); #1; cs("r_dec", 4'd1, V_DEC);
    @(negedge clk); #1; cs("r_exec", 4'd2, V_EXR);
    @(negedge clk); #1; cs("r_wb", 4'd7, V_WBR);

    // lw with stalls; IR changes after DECODE must be ignored
    @(negedge clk); opcode = 4'h8; #1; cs("lw_fetch", 4'd0, V_F1);
    @(negedge clk); #1; cs("lw_dec", 4'd1, V_DEC);
    @(negedge clk); opcode = 4'h9; #1; cs("lw_addr", 4'd4, V_MA);
    @(negedge clk); mif.mem_ready = 1'b0; #1; cs("lw_rd0", 4'd5, V_MR);
    @(negedge clk); #1; cs("lw_rd1", 4'd5, V_MR);
    @(negedge clk); #1; cs("lw_rd2", 4'd5, V_MR);
    @(negedge clk); mif.mem_ready = 1'b1; #1; cs("lw_rd3", 4'd5, V_MR);
    @(negedge clk); #1; cs("lw_wb", 4'd9, V_WBLD);

    // beq taken
    @(negedge clk); opcode = 4'hA; zero = 1'b1; #1;
    cs("beq_fetch", 4'd0, V_F1);
    @(negedge clk); #1; cs("beq_dec", 4'd1, V_DEC);
    @(negedge clk); #1; cs("beq_br", 4'd10, V_BR1);

    // bne with zero=1 not taken, zero=0 taken
    @(negedge clk); opcode = 4'hB; #1; cs("bne_fetch", 4'd0, V_F1);
    @(negedge clk); #1; cs("bne_dec", 4'd1, V_DEC);
    @(negedge clk); #1; cs("bne_br_z1", 4'd10, V_BR0);
    zero = 1'b0; #1; cs("bne_br_z0", 4'd10, V_BR1);

    // undefined opcode acts as NOP
    @(negedge clk); opcode = 4'h7; #1; cs("undef_fetch", 4'd0, V_F1);
    @(negedge clk); #1; cs("undef_dec", 4'd1, V_DEC);

    // andi
    @(negedge clk); opcode = 4'h2; #1; cs("andi_fetch", 4'd0, V_F1);
    @(negedge clk); #1; cs("andi_dec", 4'd1, V_DEC);
    @(negedge clk); #1; cs("andi_exec", 4'd3, V_EXIA);
    @(negedge clk); #1; cs("andi_wb", 4'd8, V_WBI);

    // j
    @(negedge clk); opcode = 4'hC; #1; cs("j_fetch", 4'd0, V_F1);
    @(negedge clk); #1; cs("j_dec", 4'd1, V_DEC);
    @(negedge clk); #1; cs("j_jump", 4'd11, V_JMP);

    // sw aborted by reset mid-handshake
    @(negedge clk); opcode = 4'h9; #1; cs("sw_fetch", 4'd0, V_F1);
    @(negedge clk); #1; cs("sw_dec", 4'd1, V_DEC);
    @(negedge clk); #1; cs("sw_addr", 4'd4, V_MA);
    @(negedge clk); mif.mem_ready = 1'b0; #1; cs("sw_wr0", 4'd6, V_MW);
    @(negedge clk); #1; cs("sw_wr1", 4'd6, V_MW);
    @(negedge clk); reset = 1'b1; #1; cs("sw_rst", 4'd0, V_ZERO);

    // FETCH stall then halt
    @(negedge clk); reset = 1'b0; #1; cs("f_stall", 4'd0, V_F0);
    @(negedge clk); #1; cs("f_stall2", 4'd0, V_F0);
    @(negedge clk); mif.mem_ready = 1'b1; opcode = 4'hF; #1;
    cs("halt_fetch", 4'd0, V_F1);
    @(negedge clk); #1; cs("halt_dec", 4'd1, V_DEC);
    @(negedge clk); #1; cs("halt_st", 4'd12, V_HALT);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); opcode = 4'(i * 5 + 3); #1;
      cs("halt_hold", 4'd12, V_HALT);
    end
    @(negedge clk); reset = 1'b1; #1; cs("halt_rst", 4'd0, V_ZERO);
    @(negedge clk); reset = 1'b0; opcode = 4'h0; #1;
    cs("post_rst", 4'd0, V_F1);
    @(negedge clk); #1; cs("post_dec", 4'd1, V_DEC);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main sequencing controller for the multi-cycle CPU datapath. A Moore state machine walks each instruction through fetch, decode, execute, memory and writeback. Each cycle it drives the datapath enables, the mux selects and the 3-bit `alu_op` consumed by the ALU control decoder. Memory accesses use a request/ready handshake so that the sequencer stalls on slow memory.

## Interface
- `OPC_W`, default 4: opcode field width.
- `clk`, input, 1: single system clock, rising-edge.
- `reset`, input, 1: synchronous, active-high.
- `opcode`, input, `OPC_W`: instruction opcode from the instruction register (valid from DECODE onward).
- `zero`, input, 1: ALU zero flag (valid in BRANCH).
- `mem_ready`, input, 1: memory completes the current request this cycle.
- `mem_req`, output, 1: memory request active.
- `mem_we`, output, 1: request is a write.
- `iord`, output, 1: memory address select: 0 = PC, 1 = ALUOut.
- `ir_write`, output, 1: load the instruction register.
- `pc_write`, output, 1: load the PC.
- `pc_src`, output, 2: PC source: 00 = ALU result, 01 = ALUOut (branch target), 10 = jump target.
- `alu_src_a`, output, 1: ALU A input: 0 = PC, 1 = rs.
- `alu_src_b`, output, 2: ALU B input: 00 = rt, 01 = constant 4, 10 = sign-extended immediate, 11 = shifted immediate.
- `alu_op`, output, 3: operation class sent to the ALU control decoder.
- `reg_write`, output, 1: register-file write enable.
- `reg_dst`, output, 1: destination register: 0 = rt, 1 = rd.
- `mem_to_reg`, output, 1: writeback data: 0 = ALUOut, 1 = MDR.
- `halted`, output, 1: the CPU is stopped.
- `state`, output, 4: current state encoding, for debug only.

## Operation
- States: FETCH(0), DECODE(1), EXEC_R(2), EXEC_I(3), MEM_ADDR(4), MEM_RD(5), MEM_WR(6), WB_R(7), WB_I(8), WB_LD(9), BRANCH(10), JUMP(11), HALT(12).
- Opcodes and the `alu_op` each one uses:
  - R-type 0000: 010.
  - addi 0001: 000.
  - andi 0010: 100.
  - ori 0011: 001.
  - slti 0100: 110.
  - lw 1000 and sw 1001: address add, 000.
  - beq 1010 and bne 1011: subtract, 101.
  - j 1100: no ALU operation.
  - halt 1111.
- FETCH:
  - Drives `mem_req`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=000, `pc_src`=00.
  - `ir_write` and `pc_write` are asserted only while `mem_ready`=1.
  - Advances to DECODE on `mem_ready`; otherwise holds.
- DECODE:
  - Drives `alu_src_a`=0, `alu_src_b`=11, `alu_op`=000 to precompute the branch target.
  - Next state by opcode: R → EXEC_R; addi/andi/ori/slti → EXEC_I; lw/sw → MEM_ADDR; beq/bne → BRANCH; j → JUMP; halt → HALT.
  - Any undefined opcode → FETCH, with no architectural state change (executes as a NOP).
- EXEC_R: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=010 → WB_R.
- EXEC_I: `alu_src_a`=1, `alu_src_b`=10, `alu_op` per opcode → WB_I.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=000. Next state is MEM_RD for lw, MEM_WR for sw.
- MEM_RD: `mem_req`=1, `iord`=1. Holds until `mem_ready`, then → WB_LD.
- MEM_WR: `mem_req`=1, `mem_we`=1, `iord`=1. Holds until `mem_ready`, then → FETCH.
- WB_R: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0 → FETCH.
- WB_I: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0 → FETCH.
- WB_LD: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1 → FETCH.
- BRANCH:
  - Drives `alu_src_a`=1, `alu_src_b`=00, `alu_op`=101, `pc_src`=01.
  - `pc_write` = `zero` for beq, and `~zero` for bne.
  - → FETCH.
- JUMP: `pc_src`=10, `pc_write`=1 → FETCH.
- HALT: absorbing state; `halted`=1. Only `reset` leaves it.
- Opcode latch: the controller registers `opcode` on leaving DECODE. All later states use the latched copy, so IR changes after DECODE have no effect.
- Default value of every output not listed for a state is 0.

## Timing
- All state transitions occur on the rising edge of `clk`.
- Outputs are decoded from the state register (Moore). The only combinational dependencies are:
  - `ir_write`/`pc_write` in FETCH on `mem_ready`.
  - `pc_write` in BRANCH on `zero`.
- Reset:
  - While `reset`=1, every output is 0, including `halted`. `state` reads FETCH.
  - The first cycle after `reset` falls is FETCH.
  - Reset asserted in any state, including mid-handshake, aborts the operation. No write enable may be asserted in that cycle.
- Cycle counts with `mem_ready` tied to 1:
  - R-type and I-ALU: 4.
  - lw: 5.
  - sw: 4.
  - beq/bne: 3.
  - j: 3.
  - Undefined opcode: 2.
- Each cycle of `mem_ready`=0 in FETCH, MEM_RD or MEM_WR adds one cycle. During the stall, `mem_req`, `mem_we` and `iord` hold steady.
- `mem_req` never drops before `mem_ready` is seen, except on reset.
- Exactly one `reg_write` pulse per register-writing instruction.
- At most one `pc_write` per FETCH, plus at most one in BRANCH or JUMP.

## Test plan
- Reset, then R-type with `mem_ready`=1:
  - States 0→1→2→7→0.
  - `alu_op`=010 in EXEC_R.
  - Single `reg_write` pulse with `reg_dst`=1 in cycle 4.
- lw with `mem_ready` low for 3 cycles in MEM_RD:
  - States 0,1,4,5,5,5,5,9,0.
  - `mem_req`=1 and `iord`=1 held across all four MEM_RD cycles.
  - `mem_to_reg`=1 in WB_LD.
- beq with `zero`=1, then bne with `zero`=1:
  - beq: `pc_write`=1 with `pc_src`=01 in BRANCH.
  - bne: `pc_write`=0 in BRANCH.
- Opcode 0111 (undefined):
  - DECODE→FETCH after 2 cycles.
  - No `reg_write`, `mem_req` or extra `pc_write` besides the fetch.
- halt:
  - `halted`=1 from the third cycle onward and holds for 20 cycles while `opcode` toggles.
  - `reset` pulse returns the FSM to FETCH.
- `reset` asserted in MEM_WR with `mem_ready`=0:
  - Next-cycle outputs all 0.
  - FETCH resumes after release.
  - No `mem_we` pulse completes.
